// File: rtl/st_unpack_pkg.sv
// Shared widths and beat layout for the Avalon-ST symbol unpacker.
// Defaults describe a 32-bit beat of four 8-bit symbols.
package st_unpack_pkg;

   localparam int SYMBOL_W = 8;
   localparam int SYMBOLS  = 4;
   localparam int EMPTY_W  = 2;
   localparam int ERROR_W  = 6;
   localparam int IDX_W    = $clog2(SYMBOLS);

   typedef struct packed {
      logic [SYMBOL_W*SYMBOLS-1:0] data;
      logic [ERROR_W-1:0]          error;
      logic                        sop;
      logic                        eop;
      logic [EMPTY_W-1:0]          empty;
   } beat_t;

endpackage

// File: rtl/st_symbol_unpacker.sv
// Splits one multi-symbol beat into byte-serial symbols, MSB first; first symbol one cycle after accept.
// Holds symbol while out_ready=0; next beat accepted with the last symbol. ST_UNPACK_ERR_DROP_EN drops errored beats.
module st_symbol_unpacker
   import st_unpack_pkg::*;
#(
   parameter int SYMBOL_W = st_unpack_pkg::SYMBOL_W,
   parameter int SYMBOLS  = st_unpack_pkg::SYMBOLS,
   parameter int EMPTY_W  = st_unpack_pkg::EMPTY_W,
   parameter int ERROR_W  = st_unpack_pkg::ERROR_W
) (
   input  logic                         clk,
   input  logic                         reset_n,
   output logic                         in_ready,
   input  logic                         in_valid,
   input  logic [SYMBOL_W*SYMBOLS-1:0]  in_data,
   input  logic [ERROR_W-1:0]           in_error,
   input  logic                         in_startofpacket,
   input  logic                         in_endofpacket,
   input  logic [EMPTY_W-1:0]           in_empty,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [SYMBOL_W-1:0]          out_data,
   output logic [ERROR_W-1:0]           out_error,
   output logic                         out_startofpacket,
   output logic                         out_endofpacket,
   output logic [15:0]                  drop_count
);

   localparam int IDX_W  = $clog2(SYMBOLS);
   localparam int BEAT_W = SYMBOL_W * SYMBOLS;

   logic [BEAT_W-1:0]   beat_q;
   logic [ERROR_W-1:0]  err_q;
   logic                sop_q;
   logic                eop_q;
   logic                full_q;
   logic [IDX_W-1:0]    idx_q;
   logic [IDX_W-1:0]    last_q;
   logic [IDX_W-1:0]    last_d;
   logic [SYMBOL_W-1:0] sym;
   logic                at_last;
   logic                accept;
   logic                load;
   logic                xfer;

   assign at_last  = (idx_q == last_q);
   assign in_ready = reset_n && (!full_q || (out_ready && at_last));
   assign accept   = in_valid && in_ready;
   assign xfer     = full_q && out_ready;

   // Empty only trims the tail of an eop beat; otherwise every symbol is live.
   assign last_d = in_endofpacket ? (IDX_W'(SYMBOLS - 1) - IDX_W'(in_empty))
                                  : IDX_W'(SYMBOLS - 1);

`ifdef ST_UNPACK_ERR_DROP_EN
   logic        drop;
   logic [15:0] drop_q;

   assign load = accept && (in_error == '0);
   assign drop = accept && (in_error != '0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         drop_q <= '0;
      end else if (drop && (drop_q != 16'hFFFF)) begin
         drop_q <= drop_q + 16'd1;
      end
   end

   assign drop_count = drop_q;
`else
   assign load       = accept;
   assign drop_count = '0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         full_q <= 1'b0;
         idx_q  <= '0;
      end else if (load) begin
         full_q <= 1'b1;
         idx_q  <= '0;
      end else if (xfer) begin
         if (!at_last) begin
            idx_q <= idx_q + 1'b1;
         end else begin
            full_q <= 1'b0;
         end
      end
   end

   // Payload needs no reset: every output is qualified by full_q.
   always_ff @(posedge clk) begin
      if (load) begin
         beat_q <= in_data;
         err_q  <= in_error;
         sop_q  <= in_startofpacket;
         eop_q  <= in_endofpacket;
         last_q <= last_d;
      end
   end

   always_comb begin
      sym = '0;
      for (int i = 0; i < SYMBOLS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sym = beat_q[(SYMBOLS-1-i)*SYMBOL_W +: SYMBOL_W];
         end
      end
   end

   assign out_valid         = full_q;
   assign out_data          = full_q ? sym : '0;
   assign out_error         = full_q ? err_q : '0;
   assign out_startofpacket = full_q && sop_q && (idx_q == '0);
   assign out_endofpacket   = full_q && eop_q && at_last;

endmodule

// File: tb/tb_st_symbol_unpacker.sv
// Bench for st_symbol_unpacker: directed cases plus random traffic against a symbol-queue model.
module tb_st_symbol_unpacker;
   import st_unpack_pkg::*;

   typedef struct packed {
      logic [SYMBOL_W-1:0] data;
      logic [ERROR_W-1:0]  err;
      logic                sop;
      logic                eop;
   } sym_t;

   logic                        clk = 1'b0;
   logic                        reset_n = 1'b0;
   logic                        in_ready;
   logic                        in_valid = 1'b0;
   logic [SYMBOL_W*SYMBOLS-1:0] in_data = '0;
   logic [ERROR_W-1:0]          in_error = '0;
   logic                        in_startofpacket = 1'b0;
   logic                        in_endofpacket = 1'b0;
   logic [EMPTY_W-1:0]          in_empty = '0;
   logic                        out_ready = 1'b0;
   logic                        out_valid;
   logic [SYMBOL_W-1:0]         out_data;
   logic [ERROR_W-1:0]          out_error;
   logic                        out_startofpacket;
   logic                        out_endofpacket;
   logic [15:0]                 drop_count;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   exp_drops = 0;
   sym_t exp_q[$];

   st_symbol_unpacker dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .in_ready          (in_ready),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_error          (in_error),
      .in_startofpacket  (in_startofpacket),
      .in_endofpacket    (in_endofpacket),
      .in_empty          (in_empty),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_error         (out_error),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket),
      .drop_count        (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic beat_t mk(input logic [31:0] d, input logic [ERROR_W-1:0] e,
                                input logic s, input logic eo, input logic [EMPTY_W-1:0] em);
      beat_t b;
      b.data  = d;
      b.error = e;
      b.sop   = s;
      b.eop   = eo;
      b.empty = em;
      return b;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      b.data  = $urandom;
      b.error = ($urandom_range(0, 3) == 0) ? ERROR_W'($urandom_range(1, 63)) : '0;
      b.sop   = 1'($urandom);
      b.eop   = 1'($urandom);
      b.empty = EMPTY_W'($urandom);
      return b;
   endfunction

   // Model: an accepted beat becomes its list of live symbols, MSB first.
   task automatic push_beat(input beat_t b);
      int   n;
      sym_t s;
      n = b.eop ? (SYMBOLS - int'(b.empty)) : SYMBOLS;
      for (int i = 0; i < n; i++) begin
         s.data = b.data[(SYMBOLS-1-i)*SYMBOL_W +: SYMBOL_W];
         s.err  = b.error;
         s.sop  = b.sop && (i == 0);
         s.eop  = b.eop && (i == n - 1);
         exp_q.push_back(s);
      end
   endtask

   // One clock: drive inputs after the edge, check outputs mid-cycle, advance the model.
   task automatic cycle(input logic rst, input logic v, input beat_t b, input logic ordy,
                        output logic acc);
      logic exp_rdy;
      logic drop;
      sym_t s;
      @(posedge clk);
      #1;
      reset_n          = rst;
      in_valid         = v;
      in_data          = b.data;
      in_error         = b.error;
      in_startofpacket = b.sop;
      in_endofpacket   = b.eop;
      in_empty         = b.empty;
      out_ready        = ordy;
      @(negedge clk);
      exp_rdy = rst && ((exp_q.size() == 0) || ((exp_q.size() == 1) && ordy));
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         s = exp_q[0];
         check("out_data", 32'(out_data), 32'(s.data));
         check("out_error", 32'(out_error), 32'(s.err));
         check("out_sop", 32'(out_startofpacket), 32'(s.sop));
         check("out_eop", 32'(out_endofpacket), 32'(s.eop));
      end
      check("drop_count", 32'(drop_count), 32'(exp_drops));
      acc = v && exp_rdy;
      if (!rst) begin
         exp_q.delete();
         exp_drops = 0;
      end else begin
         if ((exp_q.size() != 0) && ordy) void'(exp_q.pop_front());
         if (acc) begin
            drop = 1'b0;
`ifdef ST_UNPACK_ERR_DROP_EN
            drop = (b.error != '0);
`endif
            if (drop) begin
               if (exp_drops < 65535) exp_drops++;
            end else begin
               push_beat(b);
            end
         end
      end
   endtask

   task automatic idle(input int n, input logic ordy);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, ordy, acc);
   endtask

   task automatic send(input beat_t b, input logic ordy);
      logic acc;
      acc = 1'b0;
      for (int t = 0; t < 40 && !acc; t++) cycle(1'b1, 1'b1, b, ordy, acc);
      check("send_accepted", 32'(acc), 32'd1);
   endtask

   initial begin
      logic  acc;
      beat_t pend;
      logic  have_pend;

      // Reset state
      cycle(1'b0, 1'b0, '0, 1'b0, acc);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_error", 32'(out_error), 32'd0);
      check("rst_out_sop", 32'(out_startofpacket), 32'd0);
      check("rst_out_eop", 32'(out_endofpacket), 32'd0);
      idle(1, 1'b1);

      // Single full beat
      send(mk(32'hA1B2C3D4, '0, 1'b1, 1'b1, 2'd0), 1'b1);
      idle(5, 1'b1);

      // Empty=2: two symbols, next beat accepted on the second
      cycle(1'b1, 1'b1, mk(32'h11223344, '0, 1'b1, 1'b1, 2'd2), 1'b1, acc);
      idle(1, 1'b1);
      cycle(1'b1, 1'b1, mk(32'h55667788, '0, 1'b1, 1'b1, 2'd0), 1'b1, acc);
      check("empty_next_accept", 32'(acc), 32'd1);
      idle(5, 1'b1);

      // Back-to-back three-beat packet
      send(mk(32'h01020304, '0, 1'b1, 1'b0, 2'd3), 1'b1);
      send(mk(32'h05060708, '0, 1'b0, 1'b0, 2'd1), 1'b1);
      send(mk(32'h090A0B0C, '0, 1'b0, 1'b1, 2'd0), 1'b1);
      idle(5, 1'b1);

      // Backpressure 1010...
      send(mk(32'hDEADBEEF, '0, 1'b1, 1'b1, 2'd0), 1'b1);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0, (i % 2) == 0, acc);
      idle(2, 1'b1);

      // Reset after two of four symbols
      send(mk(32'hCAFEF00D, '0, 1'b1, 1'b1, 2'd0), 1'b1);
      idle(2, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b1, acc);
      cycle(1'b1, 1'b1, mk(32'h13579BDF, '0, 1'b1, 1'b1, 2'd0), 1'b1, acc);
      check("post_reset_accept", 32'(acc), 32'd1);
      idle(5, 1'b1);

      // Errored beat between two clean beats
      send(mk(32'h21222324, '0, 1'b1, 1'b0, 2'd0), 1'b1);
      send(mk(32'h31323334, 6'h04, 1'b0, 1'b0, 2'd0), 1'b1);
      send(mk(32'h41424344, '0, 1'b0, 1'b1, 2'd0), 1'b1);
      idle(6, 1'b1);

      // Random traffic with random backpressure
      have_pend = 1'b0;
      pend = '0;
      for (int i = 0; i < 1500; i++) begin
         if (!have_pend && ($urandom_range(0, 3) != 0)) begin
            pend = rand_beat();
            have_pend = 1'b1;
         end
         cycle(1'b1, have_pend, have_pend ? pend : beat_t'('0), 1'($urandom_range(0, 2) != 0), acc);
         if (acc) have_pend = 1'b0;
      end
      idle(8, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
